// File: rtl/skid_reg_pkg.sv
// Shared types and constants for the skid_reg pipeline register.
// Holds the occupancy state encoding and the transfer-counter geometry.
package skid_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  localparam int                    XFER_CNT_W   = 16;
  localparam logic [XFER_CNT_W-1:0] XFER_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/skid_reg_slot.sv
// Purpose: load-enabled data register, synchronous reset to RSTVAL.
// Latency: q updates on the posedge following a cycle with load high.
// Backpressure: none; the caller decides when to load.
// Ports: clk, rst_n (sync, active-low), load, d[WIDTH], q[WIDTH].
module skid_reg_slot #(
  parameter int               WIDTH  = 4,
  parameter logic [WIDTH-1:0] RSTVAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RSTVAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/skid_reg.sv
// Purpose: two-entry valid/ready pipeline register (main + skid slot) that
//   cuts the combinational ready path between producer and consumer.
// Latency: 1 cycle from input accept to out_valid; 1 word/cycle sustained.
// Backpressure: in_ready comes from registered state only; one extra word is
//   absorbed into the skid slot after out_ready drops.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready/in_data,
//   out_valid/out_ready/out_data, xfer_cnt[16].
// Option: define SKID_REG_XFER_CNT_EN to build the saturating output-transfer
//   counter; otherwise xfer_cnt is tied to zero.
module skid_reg
  import skid_reg_pkg::*;
#(
  parameter int               WIDTH  = 4,
  parameter logic [WIDTH-1:0] RSTVAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [XFER_CNT_W-1:0] xfer_cnt
);

  skid_state_t      state_q;
  skid_state_t      state_nxt;
  logic             in_fire;
  logic             out_fire;
  logic             main_load;
  logic             skid_load;
  logic             main_from_skid;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  // Ready is gated by rst_n so nothing is accepted while reset is asserted.
  assign in_ready  = (state_q != TWO) & rst_n;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_nxt = ONE;
          main_load = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          state_nxt = TWO;
          skid_load = 1'b1;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        // Skid is left as-is after the copy; it is dead until reloaded.
        if (out_fire) begin
          state_nxt      = ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  skid_reg_slot #(
    .WIDTH  (WIDTH),
    .RSTVAL (RSTVAL)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  skid_reg_slot #(
    .WIDTH  (WIDTH),
    .RSTVAL (RSTVAL)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_q)
  );

`ifdef SKID_REG_XFER_CNT_EN
  logic [XFER_CNT_W-1:0] xfer_cnt_q;

  // Saturates rather than wrapping so a stuck-high count is unambiguous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt_q <= '0;
    end else if (out_fire && (xfer_cnt_q != XFER_CNT_MAX)) begin
      xfer_cnt_q <= xfer_cnt_q + XFER_CNT_W'(1);
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_skid_reg.sv
// Directed self-checking bench for skid_reg (WIDTH=4, RSTVAL=4'hA).
// Inputs change 1 time unit after each posedge; outputs are sampled there.
// Counter expectations follow SKID_REG_XFER_CNT_EN.
module tb_skid_reg;
  import skid_reg_pkg::*;

  localparam int         W   = 4;
  localparam logic [3:0] RV  = 4'hA;
`ifdef SKID_REG_XFER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [W-1:0]          out_data;
  logic [XFER_CNT_W-1:0] xfer_cnt;

  int total;
  int bad;
  int xfers;

  skid_reg #(
    .WIDTH  (W),
    .RSTVAL (RV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 4'h3; out_ready = 1'b1;
    step();
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== RV) begin bad++; $display("FAIL rst_out_data got=%h exp=%h", out_data, RV); end
    total++; if (xfer_cnt !== 16'h0) begin bad++; $display("FAIL rst_xfer_cnt got=%h exp=0", xfer_cnt); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%b exp=1", in_ready); end
    xfers = 0;
  endtask

  task automatic test_stream();
    logic [3:0] words [4];
    logic [15:0] exp_cnt;
    words = '{4'h1, 4'h2, 4'h3, 4'h4};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = words[i];
      step();
      total++; if (out_valid !== 1'b1 || out_data !== words[i])
        begin bad++; $display("FAIL stream_out[%0d] got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, words[i]); end
      total++; if (in_ready !== 1'b1)
        begin bad++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
    end
    in_valid = 1'b0;
    step();
    xfers += 4;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got v=%b exp=0", out_valid); end
    exp_cnt = CNT_EN ? 16'(xfers) : 16'h0;
    total++; if (xfer_cnt !== exp_cnt) begin bad++; $display("FAIL stream_xfer_cnt got=%h exp=%h", xfer_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_cnt;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h5;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 4'h5 || in_ready !== 1'b1)
      begin bad++; $display("FAIL bp_one got v=%b d=%h r=%b exp v=1 d=5 r=1", out_valid, out_data, in_ready); end
    in_data = 4'h6;
    step();
    total++; if (out_data !== 4'h5 || in_ready !== 1'b0)
      begin bad++; $display("FAIL bp_two got d=%h r=%b exp d=5 r=0", out_data, in_ready); end
    in_data = 4'h7;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 4'h5 || in_ready !== 1'b0)
      begin bad++; $display("FAIL bp_hold got v=%b d=%h r=%b exp v=1 d=5 r=0", out_valid, out_data, in_ready); end
    out_ready = 1'b1;
    step();
    total++; if (out_data !== 4'h6 || in_ready !== 1'b1)
      begin bad++; $display("FAIL bp_release got d=%h r=%b exp d=6 r=1", out_data, in_ready); end
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 4'h7)
      begin bad++; $display("FAIL bp_third got v=%b d=%h exp v=1 d=7", out_valid, out_data); end
    in_valid = 1'b0;
    step();
    xfers += 3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got v=%b exp=0", out_valid); end
    exp_cnt = CNT_EN ? 16'(xfers) : 16'h0;
    total++; if (xfer_cnt !== exp_cnt) begin bad++; $display("FAIL bp_xfer_cnt got=%h exp=%h", xfer_cnt, exp_cnt); end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h8;
    step();
    total++; if (out_data !== 4'h8 || out_valid !== 1'b1)
      begin bad++; $display("FAIL sim_load got v=%b d=%h exp v=1 d=8", out_valid, out_data); end
    in_data = 4'h9; out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 4'h9 || in_ready !== 1'b1)
      begin bad++; $display("FAIL sim_swap got v=%b d=%h r=%b exp v=1 d=9 r=1", out_valid, out_data, in_ready); end
    in_valid = 1'b0;
    step();
    xfers += 2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sim_drain got v=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_in_two();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h3;
    step();
    in_data = 4'h4;
    step();
    total++; if (in_ready !== 1'b0 || out_data !== 4'h3)
      begin bad++; $display("FAIL rtwo_fill got r=%b d=%h exp r=0 d=3", in_ready, out_data); end
    in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
    step();
    total++; if (out_valid !== 1'b0 || out_data !== RV || in_ready !== 1'b0)
      begin bad++; $display("FAIL rtwo_reset got v=%b d=%h r=%b exp v=0 d=%h r=0", out_valid, out_data, in_ready, RV); end
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rtwo_in_ready got=%b exp=1", in_ready); end
    step();
    total++; if (out_valid !== 1'b0 || out_data !== RV)
      begin bad++; $display("FAIL rtwo_discard got v=%b d=%h exp v=0 d=%h", out_valid, out_data, RV); end
    total++; if (xfer_cnt !== 16'h0) begin bad++; $display("FAIL rtwo_xfer_cnt got=%h exp=0", xfer_cnt); end
  endtask

  task automatic test_saturate();
    logic [15:0] exp_seq [4];
`ifdef SKID_REG_XFER_CNT_EN
    exp_seq = '{16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    force dut.xfer_cnt_q = 16'hFFFD;
    #1;
    release dut.xfer_cnt_q;
    #1;
`else
    exp_seq = '{16'h0, 16'h0, 16'h0, 16'h0};
`endif
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 4'hC;
    step();
    for (int i = 0; i < 4; i++) begin
      in_data = 4'(i);
      step();
      total++; if (xfer_cnt !== exp_seq[i])
        begin bad++; $display("FAIL sat_cnt[%0d] got=%h exp=%h", i, xfer_cnt, exp_seq[i]); end
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    total = 0; bad = 0; xfers = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_simultaneous();
    test_reset_in_two();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
